cmd_input_frontend: RTL
=======================

CMD_INPUT_FRONTEND -- requirements
Module: cmd_input_frontend

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, number of consecutive stable synchronized samples that qualify a press or release.
REQ-002 Parameter LONG_PRESS_CYCLES, default 2000000, confirm hold time after its pulse that raises a long-press exit.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sw_cmd  input  3  raw command switches, asynchronous.
REQ-006 btn_confirm_raw  input  1  raw confirm button, active-high, asynchronous, bouncing.
REQ-007 btn_exit_raw  input  1  raw exit button, active-high, asynchronous, bouncing.
REQ-008 command  output  3  command code, registered, valid with and held after btn_confirm.
REQ-009 btn_confirm  output  1  single-cycle confirm pulse.
REQ-010 btn_exit  output  1  single-cycle exit pulse.

Function
REQ-011 All raw inputs SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each button SHALL be qualified by an FSM: IDLE -> PRESS_WAIT (sync=1) -> HELD (DEBOUNCE_CYCLES consecutive 1s) -> RELEASE_WAIT (sync=0) -> IDLE (DEBOUNCE_CYCLES consecutive 0s).
REQ-013 Any opposite sample in PRESS_WAIT SHALL return to IDLE; any opposite sample in RELEASE_WAIT SHALL return to HELD; the counter SHALL clear on every state change.
REQ-014 Entry into HELD SHALL produce exactly one 1-cycle pulse; total latency from first raw-high edge of a clean press to pulse high SHALL be DEBOUNCE_CYCLES+3 clock edges.
REQ-015 A button held indefinitely SHALL produce no further pulse until release is qualified.
REQ-016 On the edge btn_confirm rises, command SHALL load the synchronized sw_cmd; command SHALL hold otherwise.
REQ-017 If confirm and exit qualify on the same cycle, btn_exit SHALL pulse, btn_confirm SHALL stay 0 and command SHALL not update; the confirm FSM SHALL still enter HELD.
REQ-018 sw_cmd changes without a confirm press SHALL not change command.
REQ-019 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); counter SHALL saturate, never wrap.

Reset
REQ-020 During reset: command=3'd0, btn_confirm=0, btn_exit=0, synchronizers=0, both FSMs=IDLE, counters=0.
REQ-021 A button held through reset deassertion SHALL be treated as a new press (one pulse after DEBOUNCE_CYCLES+3 edges).
REQ-022 Reset asserted mid-debounce SHALL abort the count; no pulse SHALL be emitted for that press.

Configuration
REQ-023 With CMD_LONG_PRESS_EXIT_EN defined, confirm remaining HELD for LONG_PRESS_CYCLES after its pulse SHALL emit exactly one btn_exit pulse per hold; release before then SHALL emit nothing.
REQ-024 Without CMD_LONG_PRESS_EXIT_EN, btn_exit SHALL derive only from btn_exit_raw and no long-press counter SHALL be synthesized.

Structure
REQ-025 Debounce FSM state encoding (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and command code constants (0 idle, 1 data input, 2 generate, 3 display, 4 calculation) SHALL reside in the shared project package.
REQ-026 One sub-module btn_debounce (synchronizer + FSM + counter + pulse) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16)
REQ-027 sw_cmd=2, clean confirm press held 20 cycles -> one btn_confirm pulse 7 edges after raw rise, command=2 same cycle, held after.
REQ-028 Confirm bounce 1,0,1,0 at 1-cycle spacing then stable high -> single pulse counted from last rising edge; no pulse during bounce.
REQ-029 Confirm and exit raw rise on same edge, held -> btn_exit pulses once, btn_confirm stays 0, command unchanged.
REQ-030 Confirm held, rst_n pulsed low at cycle 3 of debounce, held through release -> no pulse before reset, one pulse 7 edges after rst_n rises.
REQ-031 CMD_LONG_PRESS_EXIT_EN defined, confirm held 40 cycles -> btn_confirm pulse, then one btn_exit pulse 16 cycles later, nothing else; undefined -> btn_confirm pulse only.
REQ-032 sw_cmd toggled 0..7 with no button activity -> command stays at last confirmed value, no pulses.

Source files
------------

// File: rtl/cmd_input_frontend_pkg.sv
// cmd_input_frontend_pkg
// Types and constants shared by the command input front end:
//   db_state_e  - button qualification FSM states
//   CMD_*       - command codes carried on cmd_input_frontend.command
//   cnt_width() - width of a counter that must hold 0..n without wrapping
package cmd_input_frontend_pkg;

  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_HELD         = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam logic [2:0] CMD_IDLE       = 3'd0;
  localparam logic [2:0] CMD_DATA_INPUT = 3'd1;
  localparam logic [2:0] CMD_GENERATE   = 3'd2;
  localparam logic [2:0] CMD_DISPLAY    = 3'd3;
  localparam logic [2:0] CMD_CALC       = 3'd4;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cmd_input_frontend_btn_debounce.sv
// btn_debounce
// Synchronises one raw button and qualifies presses and releases.
//
//   state           | meaning
//   ----------------+-----------------------------------------------
//   DB_IDLE         | released, waiting for a synchronized 1
//   DB_PRESS_WAIT   | counting consecutive 1s toward a qualified press
//   DB_HELD         | press qualified, waiting for a synchronized 0
//   DB_RELEASE_WAIT | counting consecutive 0s toward a qualified release
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   raw         - asynchronous raw button level (active-high)
//   rise        - combinational strobe, high in the cycle whose closing edge
//                 moves the FSM into DB_HELD (caller registers it)
//   state       - current FSM state
module btn_debounce
  import cmd_input_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      raw,
  output logic      rise,
  output db_state_e state
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]    sync_q, sync_d;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s;

  assign s     = sync_q[1];
  assign state = state_q;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    state_d = state_q;
    // Saturating increment: the compare below exits before CNT_MAX, the
    // saturation only guards against ever wrapping.
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    rise    = 1'b0;
    case (state_q)
      DB_IDLE: begin
        cnt_d = '0;
        if (s) state_d = DB_PRESS_WAIT;
      end
      DB_PRESS_WAIT: begin
        if (!s) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HELD;
          cnt_d   = '0;
          rise    = 1'b1;
        end
      end
      DB_HELD: begin
        cnt_d = '0;
        if (!s) state_d = DB_RELEASE_WAIT;
      end
      DB_RELEASE_WAIT: begin
        if (s) begin
          state_d = DB_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_input_frontend.sv
// cmd_input_frontend
// Turns raw command switches and two bouncing buttons into a registered
// command code plus single-cycle confirm/exit pulses.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   sw_cmd[2:0]      - raw command switches (asynchronous)
//   btn_confirm_raw  - raw confirm button (active-high, bouncing)
//   btn_exit_raw     - raw exit button (active-high, bouncing)
//   command[2:0]     - command code, loaded together with btn_confirm
//   btn_confirm      - one-cycle confirm pulse
//   btn_exit         - one-cycle exit pulse
//
// Build option: define CMD_LONG_PRESS_EXIT_EN to make a confirm hold of
// LONG_PRESS_CYCLES after its pulse also raise one btn_exit pulse.
module cmd_input_frontend
  import cmd_input_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 20000,
  parameter int LONG_PRESS_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw_cmd,
  input  logic       btn_confirm_raw,
  input  logic       btn_exit_raw,
  output logic [2:0] command,
  output logic       btn_confirm,
  output logic       btn_exit
);

  logic [2:0] sw_sync1_q, sw_sync1_d;
  logic [2:0] sw_sync2_q, sw_sync2_d;
  logic [2:0] command_q, command_d;
  logic       btn_confirm_q, btn_confirm_d;
  logic       btn_exit_q, btn_exit_d;

  logic       conf_rise, exit_rise, lp_fire, exit_event;
  db_state_e  conf_state;
  db_state_e  exit_state_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_confirm_raw),
    .rise  (conf_rise),
    .state (conf_state)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_exit_raw),
    .rise  (exit_rise),
    .state (exit_state_unused)
  );

`ifdef CMD_LONG_PRESS_EXIT_EN
  localparam int              LPW     = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [LPW-1:0]  LP_LAST = LPW'(LONG_PRESS_CYCLES - 1);
  localparam logic [LPW-1:0]  LP_MAX  = LPW'(LONG_PRESS_CYCLES);
  localparam logic [LPW-1:0]  LP_ONE  = LPW'(1);

  logic [LPW-1:0] lp_cnt_q, lp_cnt_d;

  // Counts only while confirm sits in HELD. A release bounce (RELEASE_WAIT)
  // freezes the count so a release started before the limit cannot fire,
  // and parking at LP_MAX keeps it to one exit pulse per hold.
  always_comb begin
    lp_cnt_d = lp_cnt_q;
    lp_fire  = 1'b0;
    case (conf_state)
      DB_HELD: begin
        if (lp_cnt_q != LP_MAX) begin
          lp_cnt_d = lp_cnt_q + LP_ONE;
          lp_fire  = (lp_cnt_q == LP_LAST);
        end
      end
      DB_RELEASE_WAIT: lp_cnt_d = lp_cnt_q;
      default:         lp_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lp_cnt_q <= '0;
    else        lp_cnt_q <= lp_cnt_d;
  end
`else
  // Without the long-press option the confirm state and the hold length are
  // not needed; the *_unused names mark that on purpose.
  localparam int lp_cycles_unused = LONG_PRESS_CYCLES;
  db_state_e conf_state_unused;
  assign conf_state_unused = conf_state;
  assign lp_fire = 1'b0;
`endif

  always_comb begin
    sw_sync1_d = sw_cmd;
    sw_sync2_d = sw_sync1_q;
    exit_event = exit_rise | lp_fire;
    // Exit wins a same-cycle tie; the confirm FSM still advances to HELD.
    btn_confirm_d = conf_rise & ~exit_event;
    btn_exit_d    = exit_event;
    command_d     = btn_confirm_d ? sw_sync2_q : command_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync1_q    <= 3'd0;
      sw_sync2_q    <= 3'd0;
      command_q     <= CMD_IDLE;
      btn_confirm_q <= 1'b0;
      btn_exit_q    <= 1'b0;
    end else begin
      sw_sync1_q    <= sw_sync1_d;
      sw_sync2_q    <= sw_sync2_d;
      command_q     <= command_d;
      btn_confirm_q <= btn_confirm_d;
      btn_exit_q    <= btn_exit_d;
    end
  end

  assign command     = command_q;
  assign btn_confirm = btn_confirm_q;
  assign btn_exit    = btn_exit_q;

endmodule
